// File: rtl/rom_loader.sv
// rom_loader
//   Copies one length-prefixed image from the cartridge ROM byte stream into
//   local program BRAM. The image starts at ROM_BASE with a 2-byte
//   little-endian length header. The payload bytes follow the header and are
//   written to BRAM addresses 0..len-1.
//
//   Optional feature macro: CHECKSUM_EN
//     When it is defined, one more byte is read after the payload. That byte
//     must equal the 8-bit sum of the payload bytes, otherwise error_out is set.
//     When it is undefined, no trailing byte is read and the sum logic is absent.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   start_in      1-cycle pulse that starts a load; only honoured in IDLE
//   rom_valid_in  1-cycle strobe meaning rom_data_in is valid
//   rom_data_in   byte from the ROM reader
//   rom_addr_out  ROM address the reader fetches next
//   wr_en_out     BRAM write enable, one cycle per payload byte
//   wr_addr_out   BRAM write address
//   wr_data_out   BRAM write data
//   busy_out      high from an accepted start until the load finishes
//   done_out      1-cycle pulse when the load finishes (success or error)
//   error_out     sticky error flag; cleared by the next accepted start
module rom_loader #(
  parameter logic [15:0] ROM_BASE   = 16'h0000,
  parameter int          DEPTH      = 4096,
  parameter int          ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  rom_valid_in,
  input  logic [7:0]            rom_data_in,
  output logic [15:0]           rom_addr_out,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [7:0]            wr_data_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_CHECK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_PAYLOAD
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [15:0]           rom_addr_q, rom_addr_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] hdr_len;
  logic        hdr_too_big;
  logic        last_byte;

  // A byte only counts once a load is in progress; strobes in IDLE are dropped.
  assign accept      = rom_valid_in && (state_q != S_IDLE);
  // The header length is complete the moment the high byte arrives.
  assign hdr_len     = {rom_data_in, len_q[7:0]};
  assign hdr_too_big = 17'(hdr_len) > 17'(DEPTH);
  // 17-bit compare so that len == DEPTH (counter wraps to 0 after the last
  // byte) is still recognised correctly.
  assign last_byte   = (17'(cnt_q) + 17'd1) == 17'(len_q);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
`ifdef CHECKSUM_EN
    sum_d      = sum_q;
`endif

    if (accept) begin
      rom_addr_d = rom_addr_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d    = S_LEN_LO;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          rom_addr_d = ROM_BASE;
          cnt_d      = '0;
`ifdef CHECKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rom_data_in;
          state_d    = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = rom_data_in;
          if (hdr_too_big) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (hdr_len == 16'd0) begin
`ifdef CHECKSUM_EN
            state_d = S_CHECK;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = rom_data_in;
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
`ifdef CHECKSUM_EN
          sum_d     = sum_q + rom_data_in;
`endif
          if (last_byte) begin
`ifdef CHECKSUM_EN
            state_d = S_CHECK;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
`endif
          end
        end
      end

`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          error_d = (rom_data_in != sum_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      rom_addr_q <= ROM_BASE;
      len_q      <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rom_addr_out = rom_addr_q;
  assign wr_en_out    = wr_en_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign error_out    = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//   Self-checking bench for rom_loader. Table-driven loads plus hand-written
//   sequences for reset and idle behaviour. Expected BRAM writes are queued
//   as bytes are driven and popped when the DUT asserts wr_en_out.
module tb_rom_loader;

  localparam logic [15:0] ROM_BASE = 16'h0000;
  localparam int          DEPTH    = 4096;
  localparam int          AW       = 12;
`ifdef CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_in = 1'b0;
  logic          rom_valid_in = 1'b0;
  logic [7:0]    rom_data_in = 8'h00;
  logic [15:0]   rom_addr_out;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [7:0]    wr_data_out;
  logic          busy_out;
  logic          done_out;
  logic          error_out;

  always #5 clk = ~clk;

  rom_loader #(.ROM_BASE(ROM_BASE), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .start_in    (start_in),
    .rom_valid_in(rom_valid_in),
    .rom_data_in (rom_data_in),
    .rom_addr_out(rom_addr_out),
    .wr_en_out   (wr_en_out),
    .wr_addr_out (wr_addr_out),
    .wr_data_out (wr_data_out),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .error_out   (error_out)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  bit exp_done_wr = 1'b0;
  logic [AW+7:0] exp_q[$];
  logic [7:0]    fixed_pl[$];

  typedef struct {
    logic [15:0] len;
    bit          bad_csum;
    bit          start_valid;
    bit          mid_start;
    int          exp_writes;
    bit          exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [AW+7:0] e;
    if (wr_en_out === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%02h expected=none", wr_addr_out, wr_data_out);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr_out, wr_data_out} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                   wr_addr_out, wr_data_out, e[AW+7:8], e[7:0]);
        end
      end
    end
    if (done_out === 1'b1) begin
      done_count++;
      checks++;
      if (wr_en_out !== exp_done_wr) begin
        errors++;
        $display("FAIL done_with_write: got wr_en=%0b expected=%0b", wr_en_out, exp_done_wr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    rom_valid_in = 1'b1;
    rom_data_in  = b;
    step();
    rom_valid_in = 1'b0;
    if ($urandom_range(0, 1) == 1) step();
  endtask

  task automatic do_start(input bit with_valid);
    start_in     = 1'b1;
    rom_valid_in = with_valid;
    rom_data_in  = 8'h5A;
    step();
    start_in     = 1'b0;
    rom_valid_in = 1'b0;
    chk("start_busy", 32'(busy_out), 32'd1);
    chk("start_err_clr", 32'(error_out), 32'd0);
    chk("start_addr", 32'(rom_addr_out), 32'(ROM_BASE));
  endtask

  task automatic run_load(input int idx, input vec_t v);
    int         nfeed;
    logic [7:0] b;
    logic [7:0] sum;
    wr_count    = 0;
    done_count  = 0;
    exp_done_wr = !CS && (v.len != 16'd0) && (17'(v.len) <= 17'(DEPTH));
    sum         = 8'd0;
    do_start(v.start_valid);
    feed(v.len[7:0]);
    feed(v.len[15:8]);
    nfeed = 2;
    if (17'(v.len) <= 17'(DEPTH)) begin
      for (int i = 0; i < int'(v.len); i++) begin
        if (fixed_pl.size() > 0) b = fixed_pl.pop_front();
        else b = 8'($urandom);
        exp_q.push_back({AW'(i), b});
        sum = sum + b;
        feed(b);
        nfeed++;
        if (v.mid_start && i == 1) begin
          start_in = 1'b1;
          step();
          start_in = 1'b0;
        end
      end
      if (CS) begin
        feed(v.bad_csum ? sum + 8'd1 : sum);
        nfeed++;
      end
    end
    step();
    step();
    chk("done_count", 32'(done_count), 32'd1);
    chk("writes", 32'(wr_count), 32'(v.exp_writes));
    chk("error", 32'(error_out), 32'(v.exp_err));
    chk("busy_end", 32'(busy_out), 32'd0);
    chk("rom_addr_end", 32'(rom_addr_out), 32'(ROM_BASE + 16'(nfeed)));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("load %0d: len=%0d writes=%0d done=%0d error=%0b rom_addr=%04h",
             idx, v.len, wr_count, done_count, error_out, rom_addr_out);
  endtask

  function automatic vec_t mk(input logic [15:0] len, input bit bad, input bit sv,
                              input bit ms, input int ew, input bit ee);
    vec_t v;
    v.len = len; v.bad_csum = bad; v.start_valid = sv;
    v.mid_start = ms; v.exp_writes = ew; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(16'd3,    1'b0, 1'b0, 1'b0, 3,    1'b0);
    tbl[1] = mk(16'd2,    1'b0, 1'b0, 1'b0, 2,    1'b0);
    tbl[2] = mk(16'd2,    1'b1, 1'b0, 1'b0, 2,    CS);
    tbl[3] = mk(16'd0,    1'b0, 1'b0, 1'b0, 0,    1'b0);
    tbl[4] = mk(16'd4097, 1'b0, 1'b0, 1'b0, 0,    1'b1);
    tbl[5] = mk(16'd4096, 1'b0, 1'b0, 1'b0, 4096, 1'b0);
    tbl[6] = mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 0,    1'b1);
    tbl[7] = mk(16'd1,    1'b0, 1'b1, 1'b0, 1,    1'b0);
    tbl[8] = mk(16'd6,    1'b0, 1'b0, 1'b1, 6,    1'b0);
    tbl[9] = mk(16'd5,    1'b1, 1'b0, 1'b0, 5,    CS);

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_rom_addr", 32'(rom_addr_out), 32'(ROM_BASE));
    chk("rst_wr_en", 32'(wr_en_out), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr_out), 32'd0);
    chk("rst_wr_data", 32'(wr_data_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);

    // Valid strobes while idle are ignored.
    wr_count = 0;
    for (int i = 0; i < 3; i++) feed(8'h11 + 8'(i));
    chk("idle_writes", 32'(wr_count), 32'd0);
    chk("idle_rom_addr", 32'(rom_addr_out), 32'(ROM_BASE));
    chk("idle_busy", 32'(busy_out), 32'd0);
    $display("idle strobes: writes=%0d rom_addr=%04h", wr_count, rom_addr_out);

    // Table of loads; the first one uses the AA,BB,CC payload.
    fixed_pl.push_back(8'hAA);
    fixed_pl.push_back(8'hBB);
    fixed_pl.push_back(8'hCC);
    for (int i = 0; i < 10; i++) run_load(i, tbl[i]);

    // Reset in the middle of a payload: no done pulse, outputs back to reset.
    wr_count   = 0;
    done_count = 0;
    do_start(1'b0);
    feed(8'h04);
    feed(8'h00);
    exp_q.push_back({AW'(0), 8'h31});
    feed(8'h31);
    exp_q.push_back({AW'(1), 8'h32});
    rom_valid_in = 1'b1;
    rom_data_in  = 8'h32;
    step();
    rom_valid_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rom_addr", 32'(rom_addr_out), 32'(ROM_BASE));
    chk("mid_rst_wr_en", 32'(wr_en_out), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr_out), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data_out), 32'd0);
    chk("mid_rst_busy", 32'(busy_out), 32'd0);
    chk("mid_rst_error", 32'(error_out), 32'd0);
    feed(8'h33);
    feed(8'h34);
    step();
    chk("mid_rst_writes", 32'(wr_count), 32'd2);
    chk("mid_rst_done", 32'(done_count), 32'd0);
    chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    $display("reset mid-load: writes=%0d done=%0d busy=%0b", wr_count, done_count, busy_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
